// File: rtl/nibble_serial_alu_ctrl_if.sv
// Host-side bus of the nibble-serial add/subtract sequencer.
//   master : issues start/op_sub/a/b and observes busy/done/result/flags
//   slave  : the sequencer itself
// Signals:
//   start, op_sub, a, b        request and operands (sampled only when idle)
//   busy, done                 status; done is a one-cycle completion pulse
//   result, sf, cf, of, pf, zf result word and PC-style flags
interface nibble_serial_alu_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;

  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             sf;
  logic             cf;
  logic             of;
  logic             pf;
  logic             zf;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, sf, cf, of, pf, zf
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, sf, cf, of, pf, zf
  );
endinterface

// File: rtl/nibble_serial_alu_ctrl.sv
// Nibble-serial add/subtract sequencer. A WIDTH-bit (4*NIBBLES) add or
// subtract is computed by reusing one external 4-bit adder slice for
// NIBBLES cycles, LSB nibble first, with the slice carry-out fed back as
// the next carry-in. Subtraction is A + ~B + 1: B is inverted when latched
// and the first carry-in is op_sub.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   bus             host interface (slave modport): start/op_sub/a/b in,
//                   busy/done/result/sf/cf/of/pf/zf out
//   slice_a/b/c0    nibble operands and carry-in driven to the adder slice
//   slice_sum/cf/of combinational sum, carry-out and overflow from the slice
module nibble_serial_alu_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  nibble_serial_alu_ctrl_if.slave         bus,
  output logic [3:0]                      slice_a,
  output logic [3:0]                      slice_b,
  output logic                            slice_c0,
  input  logic [3:0]                      slice_sum,
  input  logic                            slice_cf,
  input  logic                            slice_of
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             op_sub_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             sf_reg, cf_reg, of_reg, pf_reg, zf_reg;
  logic             busy_reg, done_reg;

  logic [IDX_W+1:0] shamt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_next;

  // Bit offset of the current nibble, plus the result with the slice sum
  // merged in so the last-nibble flags see the complete word.
  always_comb begin
    shamt    = {idx, 2'b00};
    a_sh     = a_reg >> shamt;
    b_sh     = b_reg >> shamt;
    res_next = (res_reg & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(slice_sum) << shamt);
    slice_a  = 4'h0;
    slice_b  = 4'h0;
    slice_c0 = 1'b0;
    if (state == RUN) begin
      slice_a  = a_sh[3:0];
      slice_b  = b_sh[3:0];
      slice_c0 = carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      carry      <= 1'b0;
      op_sub_reg <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      sf_reg     <= 1'b0;
      cf_reg     <= 1'b0;
      of_reg     <= 1'b0;
      pf_reg     <= 1'b0;
      zf_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_reg      <= bus.a;
            b_reg      <= bus.op_sub ? ~bus.b : bus.b;
            op_sub_reg <= bus.op_sub;
            idx        <= '0;
            carry      <= bus.op_sub;
            busy_reg   <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          res_reg <= res_next;
          carry   <= slice_cf;
          if (idx == LAST) begin
            of_reg   <= slice_of;
            // Subtract reports borrow, the inverse of the final carry.
            cf_reg   <= slice_cf ^ op_sub_reg;
            sf_reg   <= res_next[WIDTH-1];
            zf_reg   <= (res_next == '0);
            pf_reg   <= ^res_next;
            idx      <= '0;
            done_reg <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.result = res_reg;
  assign bus.sf     = sf_reg;
  assign bus.cf     = cf_reg;
  assign bus.of     = of_reg;
  assign bus.pf     = pf_reg;
  assign bus.zf     = zf_reg;
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Scoreboard bench for nibble_serial_alu_ctrl with a behavioural 4-bit
// adder slice. Expected results are pushed when an operation is issued and
// popped by an independent monitor on each done pulse.
module tb_nibble_serial_alu_ctrl;
  localparam int NIBBLES = 4;
  localparam int WIDTH   = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] slice_a, slice_b, slice_sum;
  logic       slice_c0, slice_cf, slice_of;

  nibble_serial_alu_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_alu_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_c0  (slice_c0),
    .slice_sum (slice_sum),
    .slice_cf  (slice_cf),
    .slice_of  (slice_of)
  );

  always #5 clk = ~clk;

  // Behavioural adder slice: c4 from the 5-bit sum, c3 from the low 3 bits.
  logic [4:0] s5;
  logic [3:0] s3;
  always_comb begin
    s5        = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_c0};
    s3        = {1'b0, slice_a[2:0]} + {1'b0, slice_b[2:0]} + {3'b0, slice_c0};
    slice_sum = s5[3:0];
    slice_cf  = s5[4];
    slice_of  = s5[4] ^ s3[3];
  end

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [4:0]       flags;   // {sf, cf, of, pf, zf}
    int               edge_n;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  exp_t e;
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 result=%0h", bus.result);
      end else begin
        e = sb.pop_front();
        chk("result", 32'(bus.result), 32'(e.res));
        chk("flags_sf_cf_of_pf_zf", 32'({bus.sf, bus.cf, bus.of, bus.pf, bus.zf}), 32'(e.flags));
        chk("latency_edge", 32'(cyc), 32'(e.edge_n + NIBBLES));
      end
    end
  end

  // Called at a negedge with the DUT idle; returns one negedge later.
  task automatic issue(input logic sub, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [WIDTH-1:0] er, input logic [4:0] ef);
    exp_t x;
    x.res    = er;
    x.flags  = ef;
    x.edge_n = cyc + 1;
    bus.start  = 1'b1;
    bus.op_sub = sub;
    bus.a      = av;
    bus.b      = bv;
    sb.push_back(x);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.op_sub = 1'($urandom);
    bus.a      = 16'($urandom);
    bus.b      = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("busy_timeout", 32'(bus.busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int d0;

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(bus.busy), 32'(0));
    chk("rst_done",   32'(bus.done), 32'(0));
    chk("rst_result", 32'(bus.result), 32'(0));
    chk("rst_flags",  32'({bus.sf, bus.cf, bus.of, bus.pf, bus.zf}), 32'(0));
    chk("rst_slice",  32'({slice_a, slice_b, slice_c0}), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Plain add with internal carries.
    issue(1'b0, 16'h1234, 16'h0FFF, 16'h2233, 5'b00000);
    wait_idle();

    // Carry ripples through every nibble; signed overflow.
    issue(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 5'b10110);
    chk("ripple_c0_n0", 32'(slice_c0), 32'(0));
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("ripple_c0_n%0d", k), 32'(slice_c0), 32'(1));
    end
    wait_idle();

    issue(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 5'b01001);
    wait_idle();
    issue(1'b1, 16'h0005, 16'h0005, 16'h0000, 5'b00001);
    wait_idle();
    issue(1'b1, 16'h0000, 16'h0001, 16'hFFFF, 5'b11000);
    wait_idle();
    issue(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 5'b00110);
    wait_idle();

    // Starts during RUN are ignored; a start on the first idle cycle is taken.
    d0 = done_cnt;
    issue(1'b0, 16'h1111, 16'h2222, 16'h3333, 5'b00000);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h8000; bus.b = 16'h8000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    chk("single_done", 32'(done_cnt - d0), 32'(1));
    issue(1'b1, 16'h0100, 16'h0001, 16'h00FF, 5'b00000);
    wait_idle();

    // Asynchronous abort at idx=2.
    d0 = done_cnt;
    issue(1'b0, 16'h1234, 16'h1111, 16'h2345, 5'b00000);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    chk("abort_busy",   32'(bus.busy), 32'(0));
    chk("abort_done",   32'(bus.done), 32'(0));
    chk("abort_slice",  32'({slice_a, slice_b, slice_c0}), 32'(0));
    chk("abort_result", 32'(bus.result), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'(0));
    issue(1'b0, 16'h00FF, 16'h0001, 16'h0100, 5'b00010);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
